// File: rtl/uop_queue.sv
// uop_queue: DEPTH-entry decoupling FIFO for packed micro-ops between IDU and EXU.
// Ports: clock/reset (sync, active-low), flush (redirect), in_valid/in_ready/in_uop
// (producer side), out_valid/out_ready/out_uop (consumer side), count (occupancy),
// sys_pending (a stored system uop is waiting to issue).
module uop_queue #(
    parameter int DEPTH     = 4,
    parameter int UOP_W     = 181,
    parameter int SYS_BIT   = 25,
    parameter int BYPASS    = 1,
    parameter int SERIALIZE = 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [UOP_W-1:0]         in_uop,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [UOP_W-1:0]         out_uop,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     sys_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [UOP_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sys_q, sys_d;

    logic empty, full, is_sys;
    logic enq, deq, byp;
    logic wr_en, rd_en;

    always_comb begin
        empty  = (cnt_q == '0);
        full   = (cnt_q == CW'(DEPTH));
        is_sys = in_uop[SYS_BIT];

        // in_ready never looks at out_ready: no ready-to-ready path.
        in_ready = !full && !flush && !sys_q;
        if ((SERIALIZE != 0) && is_sys && !empty) begin
            in_ready = 1'b0;
        end

        enq = in_valid && in_ready;
        byp = (BYPASS != 0) && empty && enq;

        out_valid = !empty || byp;
        out_uop   = byp ? in_uop : mem_q[rd_q];
        deq       = out_valid && out_ready;

        // A bypassed uop taken by the consumer is never written.
        wr_en = enq && !(byp && out_ready);
        // Only stored entries are popped from storage.
        rd_en = deq && !empty;
    end

    always_comb begin
        rd_d  = rd_q + PW'(rd_en);
        wr_d  = wr_q + PW'(wr_en);
        cnt_d = cnt_q + CW'(wr_en) - CW'(rd_en);

        // A stored system uop sits alone in the queue, so any pop
        // while sys_q is set retires it.
        sys_d = sys_q;
        if (rd_en) begin
            sys_d = 1'b0;
        end
        if (wr_en && is_sys && (SERIALIZE != 0)) begin
            sys_d = 1'b1;
        end

        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
            sys_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            sys_q <= 1'b0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            sys_q <= sys_d;
        end
    end

    always_ff @(posedge clock) begin
        if (reset && wr_en) begin
            mem_q[wr_q] <= in_uop;
        end
    end

    assign count       = cnt_q;
    assign sys_pending = sys_q;

endmodule

// File: tb/tb_uop_queue.sv
// tb_uop_queue: directed test of uop_queue.
// Instance u_a uses BYPASS=1, instance u_b uses BYPASS=0.
module tb_uop_queue;

    logic         clock;
    logic         reset;

    logic         flush, in_valid, out_ready;
    logic [180:0] in_uop;
    logic         in_ready, out_valid, sys_pending;
    logic [180:0] out_uop;
    logic [2:0]   count;

    logic         b_flush, b_in_valid, b_out_ready;
    logic [180:0] b_in_uop;
    logic         b_in_ready, b_out_valid, b_sys_pending;
    logic [180:0] b_out_uop;
    logic [2:0]   b_count;

    int total = 0;
    int bad   = 0;

    uop_queue #(.DEPTH(4), .UOP_W(181), .SYS_BIT(25), .BYPASS(1), .SERIALIZE(1)) u_a (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop),
        .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop),
        .count(count), .sys_pending(sys_pending)
    );

    uop_queue #(.DEPTH(4), .UOP_W(181), .SYS_BIT(25), .BYPASS(0), .SERIALIZE(1)) u_b (
        .clock(clock), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_uop(b_in_uop),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_uop(b_out_uop),
        .count(b_count), .sys_pending(b_sys_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [180:0] mk(input logic [31:0] pc, input logic sys);
        logic [180:0] m;
        m = '0;
        m[95:64]   = pc;
        m[180:149] = ~pc;
        m[25]      = sys;
        return m;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        smp();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (sys_pending !== 1'b0) begin bad++; $display("FAIL reset_sys got=%b want=0", sys_pending); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (b_count !== 3'd0 || b_sys_pending !== 1'b0) begin bad++; $display("FAIL reset_b got=%0d/%b want=0/0", b_count, b_sys_pending); end
        cyc();
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) begin
            b_in_valid  = 1'b1;
            b_in_uop    = mk(32'h8000_0000 + 32'(4 * i), 1'b0);
            b_out_ready = 1'b0;
            smp();
            total++; if (b_out_valid !== (i != 0)) begin bad++; $display("FAIL fill_out_valid[%0d] got=%b want=%b", i, b_out_valid, (i != 0)); end
            cyc();
        end
        b_in_uop = mk(32'h8000_0010, 1'b0);
        smp();
        total++; if (b_count !== 3'd4) begin bad++; $display("FAIL fill_count got=%0d want=4", b_count); end
        total++; if (b_in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", b_in_ready); end
        cyc();
        b_in_valid  = 1'b0;
        b_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            total++; if (b_out_valid !== 1'b1 || b_out_uop !== mk(32'h8000_0000 + 32'(4 * i), 1'b0)) begin
                bad++; $display("FAIL drain_order[%0d] got=%h want=%h", i, b_out_uop, mk(32'h8000_0000 + 32'(4 * i), 1'b0));
            end
            cyc();
        end
        b_out_ready = 1'b0;
        smp();
        total++; if (b_count !== 3'd0 || b_out_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%0d/%b want=0/0", b_count, b_out_valid); end
        cyc();
    endtask

    task automatic test_bypass();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_uop    = mk(32'h8000_0010, 1'b0);
        smp();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL byp_out_valid got=%b want=1", out_valid); end
        total++; if (out_uop !== mk(32'h8000_0010, 1'b0)) begin bad++; $display("FAIL byp_out_uop got=%h want=%h", out_uop, mk(32'h8000_0010, 1'b0)); end
        cyc();
        in_valid = 1'b0;
        smp();
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL byp_pass_count got=%0d/%b want=0/0", count, out_valid); end
        cyc();
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_uop    = mk(32'h8000_0014, 1'b0);
        smp();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL byp_hold_valid got=%b want=1", out_valid); end
        cyc();
        in_valid = 1'b0;
        smp();
        total++; if (count !== 3'd1) begin bad++; $display("FAIL byp_store_count got=%0d want=1", count); end
        total++; if (out_uop !== mk(32'h8000_0014, 1'b0)) begin bad++; $display("FAIL byp_store_uop got=%h want=%h", out_uop, mk(32'h8000_0014, 1'b0)); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        smp();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL byp_drain got=%0d want=0", count); end
        cyc();
    endtask

    task automatic test_full_deq();
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            in_uop    = mk(32'h100 + 32'(4 * i), 1'b0);
            cyc();
        end
        in_uop    = mk(32'h110, 1'b0);
        out_ready = 1'b1;
        smp();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", count); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
        total++; if (out_uop !== mk(32'h100, 1'b0)) begin bad++; $display("FAIL full_head got=%h want=%h", out_uop, mk(32'h100, 1'b0)); end
        cyc();
        smp();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL full_deq_count got=%0d want=3", count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_reopen got=%b want=1", in_ready); end
        total++; if (out_uop !== mk(32'h104, 1'b0)) begin bad++; $display("FAIL full_head2 got=%h want=%h", out_uop, mk(32'h104, 1'b0)); end
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        smp();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL enqdeq_count got=%0d want=3", count); end
        total++; if (out_uop !== mk(32'h108, 1'b0)) begin bad++; $display("FAIL enqdeq_head got=%h want=%h", out_uop, mk(32'h108, 1'b0)); end
        cyc();
    endtask

    task automatic test_flush();
        logic [31:0] pcs [6];
        for (int i = 0; i < 6; i++) pcs[i] = 32'h300 + 32'(4 * i);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_uop   = mk(32'h200, 1'b0);
        smp();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL flush_out_valid got=%b want=1", out_valid); end
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        smp();
        total++; if (count !== 3'd0 || out_valid !== 1'b0) begin bad++; $display("FAIL flush_empty got=%0d/%b want=0/0", count, out_valid); end
        cyc();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_uop   = mk(pcs[i], 1'b0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            smp();
            total++; if (out_uop !== mk(pcs[i], 1'b0)) begin bad++; $display("FAIL wrap_a[%0d] got=%h want=%h", i, out_uop, mk(pcs[i], 1'b0)); end
            cyc();
        end
        out_ready = 1'b0;
        for (int i = 3; i < 6; i++) begin
            in_valid = 1'b1;
            in_uop   = mk(pcs[i], 1'b0);
            cyc();
        end
        in_valid = 1'b0;
        smp();
        total++; if (count !== 3'd4) begin bad++; $display("FAIL wrap_count got=%0d want=4", count); end
        cyc();
        out_ready = 1'b1;
        for (int i = 2; i < 6; i++) begin
            smp();
            total++; if (out_uop !== mk(pcs[i], 1'b0)) begin bad++; $display("FAIL wrap_b[%0d] got=%h want=%h", i, out_uop, mk(pcs[i], 1'b0)); end
            cyc();
        end
        out_ready = 1'b0;
        smp();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL wrap_empty got=%0d want=0", count); end
        cyc();
    endtask

    task automatic test_serialize();
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            in_uop    = mk(32'h400 + 32'(4 * i), 1'b0);
            cyc();
        end
        in_uop = mk(32'h408, 1'b1);
        smp();
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ser_block2 got=%b want=0", in_ready); end
        cyc();
        out_ready = 1'b1;
        smp();
        total++; if (count !== 3'd2) begin bad++; $display("FAIL ser_count2 got=%0d want=2", count); end
        cyc();
        smp();
        total++; if (in_ready !== 1'b0 || count !== 3'd1) begin bad++; $display("FAIL ser_block1 got=%b/%0d want=0/1", in_ready, count); end
        cyc();
        out_ready = 1'b0;
        smp();
        total++; if (count !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL ser_accept got=%0d/%b want=0/1", count, in_ready); end
        total++; if (sys_pending !== 1'b0) begin bad++; $display("FAIL ser_sys_pre got=%b want=0", sys_pending); end
        cyc();
        in_uop = mk(32'h40C, 1'b0);
        smp();
        total++; if (sys_pending !== 1'b1) begin bad++; $display("FAIL ser_sys_set got=%b want=1", sys_pending); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL ser_behind got=%b want=0", in_ready); end
        cyc();
        out_ready = 1'b1;
        smp();
        total++; if (count !== 3'd1 || in_ready !== 1'b0) begin bad++; $display("FAIL ser_hold got=%0d/%b want=1/0", count, in_ready); end
        total++; if (out_uop !== mk(32'h408, 1'b1)) begin bad++; $display("FAIL ser_head got=%h want=%h", out_uop, mk(32'h408, 1'b1)); end
        cyc();
        smp();
        total++; if (sys_pending !== 1'b0) begin bad++; $display("FAIL ser_sys_clr got=%b want=0", sys_pending); end
        total++; if (in_ready !== 1'b1 || out_uop !== mk(32'h40C, 1'b0)) begin bad++; $display("FAIL ser_release got=%b/%h want=1/%h", in_ready, out_uop, mk(32'h40C, 1'b0)); end
        cyc();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        smp();
        total++; if (count !== 3'd0) begin bad++; $display("FAIL ser_end got=%0d want=0", count); end
        cyc();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            in_valid  = 1'b1;
            out_ready = 1'b0;
            in_uop    = mk(32'h500 + 32'(4 * i), 1'b0);
            cyc();
        end
        reset     = 1'b0;
        in_uop    = mk(32'h50C, 1'b0);
        out_ready = 1'b1;
        smp();
        total++; if (count !== 3'd3) begin bad++; $display("FAIL rmid_pre got=%0d want=3", count); end
        cyc();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        smp();
        total++; if (count !== 3'd0 || out_valid !== 1'b0 || sys_pending !== 1'b0) begin
            bad++; $display("FAIL rmid_state got=%0d/%b/%b want=0/0/0", count, out_valid, sys_pending);
        end
        cyc();
        in_valid = 1'b1;
        in_uop   = mk(32'h600, 1'b0);
        cyc();
        in_valid = 1'b0;
        smp();
        total++; if (count !== 3'd1 || out_uop !== mk(32'h600, 1'b0)) begin
            bad++; $display("FAIL rmid_fresh got=%0d/%h want=1/%h", count, out_uop, mk(32'h600, 1'b0));
        end
        cyc();
    endtask

    initial begin
        reset       = 1'b0;
        flush       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_uop      = '0;
        b_flush     = 1'b0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_in_uop    = '0;
        test_reset();
        test_fill_drain();
        test_bypass();
        test_full_deq();
        test_flush();
        test_serialize();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
